branch_pred_table: RTL and testbench

Parametrised successor to the single saturating-counter branch predictor. Holds a table of 2^IDX_BITS N-bit saturating counters, indexed either by PC bits (bimodal) or by PC XOR global history (gshare), with a registered prediction and a separate resolve/update port. It sits between the fetch stage, which issues lookups, and the execute stage, which resolves branches and returns the lookup index.

---
 rtl/bp_pkg.sv | 34 +++
 rtl/sat_ctr_n.sv | 32 +++
 rtl/branch_pred_table.sv | 111 +++++++++++
 tb/tb_branch_pred_table.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// ----------------------------------------------------------------------------
// bp_pkg
//   Shared definitions for the branch prediction table.
//   - BP_BIMODAL / BP_GSHARE : values for the MODE parameter.
//   - BP_MAX_N               : widest counter that sat_next can handle.
//   - sat_next()             : next value of an n-bit saturating counter.
//     The update path and the lookup forwarding path both call it, so the
//     two can never disagree about where the counter saturates.
// ----------------------------------------------------------------------------
package bp_pkg;

    localparam int BP_BIMODAL = 0;
    localparam int BP_GSHARE  = 1;

    // Counters are carried through sat_next zero-extended to this width.
    localparam int BP_MAX_N   = 16;

    // Saturating step of an n-bit counter (n <= BP_MAX_N). The counter is
    // passed zero-extended, and the caller truncates the result back to n bits.
    function automatic logic [BP_MAX_N-1:0] sat_next(
        input logic [BP_MAX_N-1:0] ctr,
        input logic                taken,
        input int                  n
    );
        logic [BP_MAX_N-1:0] top;
        // When n == BP_MAX_N the shift wraps to 0, and top becomes all ones.
        top = (BP_MAX_N'(1) << n) - BP_MAX_N'(1);
        if (taken) begin
            return (ctr == top) ? ctr : ctr + BP_MAX_N'(1);
        end
        return (ctr == '0) ? ctr : ctr - BP_MAX_N'(1);
    endfunction

endpackage

// File: rtl/sat_ctr_n.sv
// ----------------------------------------------------------------------------
// sat_ctr_n
//   One N-bit saturating up/down counter, which is one entry of the
//   prediction table.
//   Ports:
//     clk    in   clock, rising edge
//     reset  in   synchronous, active-high; clears to 0 (strongly not-taken)
//     branch in   a resolved branch updates this entry this cycle
//     taken  in   outcome: 1 counts up, 0 counts down (no wrap)
//     ctr    out  current counter value
// ----------------------------------------------------------------------------
module sat_ctr_n
    import bp_pkg::*;
#(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         branch,
    input  logic         taken,
    output logic [N-1:0] ctr
);

    always_ff @(posedge clk) begin
        if (reset) begin
            ctr <= '0;
        end else if (branch) begin
            ctr <= N'(sat_next(BP_MAX_N'(ctr), taken, N));
        end
    end

endmodule

// File: rtl/branch_pred_table.sv
// ----------------------------------------------------------------------------
// branch_pred_table
//   Table of 2^IDX_BITS N-bit saturating counters. The table is indexed by
//   the PC (bimodal) or by the PC XOR the global history (gshare). The
//   prediction is registered, and a separate port resolves branches.
//   Parameters:
//     N          counter width; the MSB set means predict taken
//     IDX_BITS   log2 of the number of table entries
//     HIST_BITS  global history length (must be <= IDX_BITS)
//     MODE       BP_BIMODAL or BP_GSHARE
//   Ports:
//     clk, reset                 clock and synchronous active-high reset
//     lk_valid, lk_pc            lookup request from fetch
//     pred_valid/taken/index     registered prediction, 1 cycle after lookup
//     upd_valid/index/taken/mispred  resolved branch from execute
//     mispred_count              saturating 16-bit mispredict count
// ----------------------------------------------------------------------------
module branch_pred_table
    import bp_pkg::*;
#(
    parameter int N         = 2,
    parameter int IDX_BITS  = 4,
    parameter int HIST_BITS = 4,
    parameter int MODE      = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                lk_valid,
    input  logic [IDX_BITS-1:0] lk_pc,
    output logic                pred_valid,
    output logic                pred_taken,
    output logic [IDX_BITS-1:0] pred_index,
    input  logic                upd_valid,
    input  logic [IDX_BITS-1:0] upd_index,
    input  logic                upd_taken,
    input  logic                upd_mispred,
    output logic [15:0]         mispred_count
);

    localparam int ENTRIES = 1 << IDX_BITS;
    // Counter values at or above this threshold have the MSB set.
    localparam logic [N-1:0] TAKEN_MIN = N'(1) << (N - 1);

    logic [ENTRIES-1:0][N-1:0] ctr_tbl;
    logic [HIST_BITS-1:0]      ghr;
    logic [IDX_BITS-1:0]       lk_idx;
    logic [N-1:0]              upd_next;
    logic [N-1:0]              lk_ctr;
    logic                      fwd_hit;

    // ---------------- counter table ----------------
    for (genvar i = 0; i < ENTRIES; i++) begin : g_ctr
        sat_ctr_n #(.N(N)) u_ctr (
            .clk    (clk),
            .reset  (reset),
            .branch (upd_valid && (upd_index == IDX_BITS'(i))),
            .taken  (upd_taken),
            .ctr    (ctr_tbl[i])
        );
    end

    // ---------------- lookup index ----------------
    // The pre-edge history is used. A same-cycle update affects only the
    // next lookup.
    always_comb begin
        lk_idx = lk_pc;
        if (MODE == BP_GSHARE) begin
            lk_idx = lk_pc ^ IDX_BITS'(ghr);
        end
    end

    // ---------------- forwarding ----------------
    // When a lookup hits the entry that is being updated in the same cycle,
    // the prediction uses the post-update value. That value is the one the
    // counter holds after this edge.
    always_comb begin
        upd_next = N'(sat_next(BP_MAX_N'(ctr_tbl[upd_index]), upd_taken, N));
        fwd_hit  = upd_valid && (upd_index == lk_idx);
        lk_ctr   = fwd_hit ? upd_next : ctr_tbl[lk_idx];
    end

    // ---------------- prediction registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            pred_valid <= 1'b0;
            pred_taken <= 1'b0;
            pred_index <= '0;
        end else begin
            pred_valid <= lk_valid;
            if (lk_valid) begin
                pred_index <= lk_idx;
                pred_taken <= (lk_ctr >= TAKEN_MIN);
            end
        end
    end

    // ---------------- history and mispredict count ----------------
    // History is non-speculative: it shifts only when a branch resolves.
    always_ff @(posedge clk) begin
        if (reset) begin
            ghr           <= '0;
            mispred_count <= '0;
        end else if (upd_valid) begin
            ghr <= HIST_BITS'({ghr, upd_taken});
            if (upd_mispred && (mispred_count != 16'hFFFF)) begin
                mispred_count <= mispred_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_branch_pred_table.sv
module tb_branch_pred_table;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        lk_valid = 1'b0;
    logic [3:0]  lk_pc = '0;
    logic        upd_valid = 1'b0;
    logic [3:0]  upd_index = '0;
    logic        upd_taken = 1'b0;
    logic        upd_mispred = 1'b0;

    logic        pv0, pt0, pv1, pt1;
    logic [3:0]  pi0, pi1;
    logic [15:0] mc0, mc1;

    always #5 clk = ~clk;

    branch_pred_table #(.N(2), .IDX_BITS(4), .HIST_BITS(4), .MODE(0)) dut0 (
        .clk(clk), .reset(reset), .lk_valid(lk_valid), .lk_pc(lk_pc),
        .pred_valid(pv0), .pred_taken(pt0), .pred_index(pi0),
        .upd_valid(upd_valid), .upd_index(upd_index), .upd_taken(upd_taken),
        .upd_mispred(upd_mispred), .mispred_count(mc0));

    branch_pred_table #(.N(2), .IDX_BITS(4), .HIST_BITS(4), .MODE(1)) dut1 (
        .clk(clk), .reset(reset), .lk_valid(lk_valid), .lk_pc(lk_pc),
        .pred_valid(pv1), .pred_taken(pt1), .pred_index(pi1),
        .upd_valid(upd_valid), .upd_index(upd_index), .upd_taken(upd_taken),
        .upd_mispred(upd_mispred), .mispred_count(mc1));

    typedef struct {
        logic        v;
        logic        t;
        logic [3:0]  i;
        logic [15:0] c;
        bit          h;
        logic        ht;
        logic [3:0]  hi;
    } exp_s;

    exp_s q0[$];
    exp_s q1[$];

    // Reference state: index 0 = bimodal DUT, index 1 = gshare DUT
    logic [1:0]  m_ctr [2][16];
    logic [3:0]  m_ghr [2];
    logic        m_v [2];
    logic        m_t [2];
    logic [3:0]  m_i [2];
    logic [15:0] m_c [2];

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [1:0] sat(input logic [1:0] c, input logic t);
        if (t) return (c == 2'd3) ? c : c + 2'd1;
        return (c == 2'd0) ? c : c - 2'd1;
    endfunction

    task automatic cmp(input string nm, input int d, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %h, expected %h (t=%0t)", nm, d, act, exp, $time);
        end
    endtask

    task automatic chkd(input int d, input exp_s e, input logic v, input logic t,
                        input logic [3:0] i, input logic [15:0] c);
        cmp("pred_valid", d, 16'(v), 16'(e.v));
        cmp("pred_taken", d, 16'(t), 16'(e.t));
        cmp("pred_index", d, 16'(i), 16'(e.i));
        cmp("mispred_count", d, c, e.c);
        if (e.h) begin
            cmp("hand_taken", d, 16'(t), 16'(e.ht));
            cmp("hand_index", d, 16'(i), 16'(e.hi));
        end
    endtask

    // Monitor: one expectation per cycle, checked 1 time unit after the edge
    initial begin
        exp_s e;
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0) begin
                e = q0.pop_front();
                chkd(0, e, pv0, pt0, pi0, mc0);
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                chkd(1, e, pv1, pt1, pi1, mc1);
            end
        end
    end

    // One cycle of stimulus. hd selects the DUT that also gets a hand-computed check (-1 = none).
    task automatic step(input logic rst, input logic lv, input logic [3:0] pc,
                        input logic uv, input logic [3:0] ui, input logic ut, input logic um,
                        input int hd, input logic ht, input logic [3:0] hi);
        exp_s       e;
        logic [3:0] idx;
        logic [1:0] c;
        @(posedge clk);
        #2;
        reset = rst; lk_valid = lv; lk_pc = pc;
        upd_valid = uv; upd_index = ui; upd_taken = ut; upd_mispred = um;
        for (int m = 0; m < 2; m++) begin
            if (rst) begin
                for (int k = 0; k < 16; k++) m_ctr[m][k] = 2'd0;
                m_ghr[m] = 4'd0; m_v[m] = 1'b0; m_t[m] = 1'b0; m_i[m] = 4'd0; m_c[m] = 16'd0;
            end else begin
                idx = (m == 1) ? (pc ^ m_ghr[m]) : pc;
                c = m_ctr[m][idx];
                if (uv && ui == idx) c = sat(c, ut);
                m_v[m] = lv;
                if (lv) begin
                    m_i[m] = idx;
                    m_t[m] = c[1];
                end
                if (uv) begin
                    m_ctr[m][ui] = sat(m_ctr[m][ui], ut);
                    m_ghr[m] = {m_ghr[m][2:0], ut};
                    if (um && m_c[m] != 16'hFFFF) m_c[m] = m_c[m] + 16'd1;
                end
            end
            e.v = m_v[m]; e.t = m_t[m]; e.i = m_i[m]; e.c = m_c[m];
            e.h = (hd == m); e.ht = ht; e.hi = hi;
            if (m == 0) q0.push_back(e);
            else q1.push_back(e);
        end
    endtask

    initial begin
        // reset (both DUTs report zeros)
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, 4'd0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0);

        // 1: gshare lookup pc=5 after reset
        step(0, 1, 4'd5, 0, 0, 0, 0, 1, 0, 4'd5);
        step(0, 0, 0, 0, 0, 0, 0, -1, 0, 0);

        // 2: bimodal saturation at index 3
        for (int k = 0; k < 5; k++) step(0, 0, 0, 1, 4'd3, 1, 0, -1, 0, 0);
        step(0, 1, 4'd3, 0, 0, 0, 0, 0, 1, 4'd3);
        step(0, 0, 0, 1, 4'd3, 0, 1, -1, 0, 0);
        step(0, 0, 0, 1, 4'd3, 0, 1, -1, 0, 0);
        step(0, 1, 4'd3, 0, 0, 0, 0, 0, 0, 4'd3);

        // 3: history 1,0,1,1 then gshare lookup pc=0110 -> index 1101
        step(1, 0, 0, 0, 0, 0, 0, -1, 0, 0);
        step(0, 0, 0, 1, 4'd15, 1, 0, -1, 0, 0);
        step(0, 0, 0, 1, 4'd15, 0, 0, -1, 0, 0);
        step(0, 0, 0, 1, 4'd15, 1, 0, -1, 0, 0);
        step(0, 0, 0, 1, 4'd15, 1, 0, -1, 0, 0);
        step(0, 1, 4'b0110, 0, 0, 0, 0, 1, 0, 4'b1101);

        // 4: forwarding on a same-cycle lookup and update of index 2
        step(1, 0, 0, 0, 0, 0, 0, -1, 0, 0);
        step(0, 0, 0, 1, 4'd2, 1, 0, -1, 0, 0);
        step(0, 1, 4'd2, 1, 4'd2, 1, 0, 0, 1, 4'd2);
        step(0, 1, 4'd2, 0, 0, 0, 0, 0, 1, 4'd2);
        step(0, 0, 0, 0, 0, 0, 0, -1, 0, 0);

        // 6: random stream against the reference model
        for (int k = 0; k < 400; k++)
            step(0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1, 0, 0);

        // 5: mispredict counter saturation, then reset with an update in flight
        step(1, 0, 0, 0, 0, 0, 0, -1, 0, 0);
        for (int k = 0; k < 65540; k++)
            step(0, 0, 0, 1, 4'(k), 1'(k % 3 == 0), 1, -1, 0, 0);
        step(1, 1, 4'd7, 1, 4'd7, 1, 1, 1, 0, 4'd0);
        for (int k = 0; k < 16; k++)
            step(0, 1, 4'(k), 0, 0, 0, 0, 0, 0, 4'(k));
        step(0, 0, 0, 0, 0, 0, 0, -1, 0, 0);

        // drain the scoreboard
        @(posedge clk);
        #3;
        @(posedge clk);
        #3;
        n_checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d/%0d entries left, expected 0", q0.size(), q1.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
